time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
- REQ-001: Parameter TICK_DIV, default 50000000: clk cycles per 1 s tick (50 MHz clock).
- REQ-002: Parameter DEBOUNCE_CYC, default 1000000: consecutive stable synchronized cycles before a button level is accepted (20 ms).
- REQ-003: Parameter BLINK_DIV, default 12500000: clk cycles per blink-phase toggle (2 Hz blink).
- REQ-004: clk  input  1  single system clock; all logic on rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous, active-low.
- REQ-006: btn_mode  input  1  raw mode button, asynchronous, active-high.
- REQ-007: btn_inc  input  1  raw increment button, asynchronous, active-high.
- REQ-008: digits  output  16  BCD time {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each; feeds the 7-segment multiplex stage.
- REQ-009: blank  output  4  per-digit blank mask, same bit order as digits; 1 = display stage blanks that digit.
- REQ-010: mode  output  2  FSM state: 00 RUN, 01 SET_MIN, 10 SET_SEC; 11 never driven.
- REQ-011: tick_1hz  output  1  one-cycle pulse on each seconds advance.

Function
- REQ-012: Each button passes through a 2-FF synchronizer, then a debounce counter; the accepted level changes only after DEBOUNCE_CYC consecutive cycles of the synchronized input differing from it; counter clears on any bounce.
- REQ-013: A press pulse (one cycle) is generated on the accepted level's 0->1 transition; release generates nothing; holding generates no repeats.
- REQ-014: Prescaler counts 0..TICK_DIV-1 in RUN only; tick_1hz asserts in the cycle the count equals TICK_DIV-1, count then wraps to 0.
- REQ-015: In SET_MIN and SET_SEC the prescaler is held at 0 and tick_1hz stays 0.
- REQ-016: Time register updates the cycle after tick_1hz: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to minutes; minutes likewise; 59:59 -> 00:00.
- REQ-017: Every BCD nibble stays in range at all times: tens 0..5, ones 0..9.
- REQ-018: FSM transitions on mode press only: RUN -> SET_MIN -> SET_SEC -> RUN; mode output updates the cycle after the press pulse.
- REQ-019: Inc press in SET_MIN increments minutes mod 60 (BCD, 59->00), seconds unchanged, no carry; in SET_SEC increments seconds mod 60, no carry into minutes.
- REQ-020: Inc press in RUN is ignored.
- REQ-021: Mode and inc press pulses in the same cycle: mode acts, inc is discarded.
- REQ-022: SET_SEC -> RUN restarts the prescaler at 0; first tick_1hz occurs exactly TICK_DIV cycles after mode changes to 00.
- REQ-023: Blink phase toggles every BLINK_DIV cycles, free-running in all states.
- REQ-024: blank = 4'b0000 in RUN; in SET_MIN blank = {phase, phase, 0, 0}; in SET_SEC blank = {0, 0, phase, phase}.
- REQ-025: Blink counter and phase reset to 0 on every mode change so the edited field starts visible.

Reset
- REQ-026: rst_n low asynchronously forces digits = 16'h0000, blank = 4'b0000, mode = 00, tick_1hz = 0, all counters, synchronizers and accepted button levels to 0.
- REQ-027: Reset mid-edit or mid-debounce aborts without a pending press; after rst_n rises, prescaler starts at 0 and first tick occurs TICK_DIV cycles later.

Verification (TICK_DIV=10, DEBOUNCE_CYC=4, BLINK_DIV=8)
- REQ-028: Release reset, run 600 cycles -> 60 tick_1hz pulses, spacing 10 cycles, digits = 16'h0100.
- REQ-029: Preload 59:59 via SET mode, return to RUN, wait 10 cycles -> digits = 16'h0000, no out-of-range nibble.
- REQ-030: btn_inc bouncing 0/1 every 2 cycles for 20 cycles, then high 10 cycles, in SET_MIN -> exactly one increment, min 00 -> 01.
- REQ-031: In SET_SEC at 00:59 press inc -> digits = 16'h0000 (seconds wrap, minutes unchanged); blank toggles 4'b0000/4'b0011 every 8 cycles.
- REQ-032: Mode and inc accepted same cycle in SET_MIN -> mode = 10, minutes unchanged.
- REQ-033: Assert rst_n low while in SET_SEC at 12:34 -> outputs immediately zero, mode = 00, first tick 10 cycles after release.

Source files
------------

// File: rtl/time_set_ctrl.sv
// MM:SS clock with two-button time setting and blinking edit field.
// Ports:
//   clk       system clock, rising edge
//   rst_n     async active-low reset
//   btn_mode  raw mode button (async, active-high)
//   btn_inc   raw increment button (async, active-high)
//   digits    BCD {min_tens, min_ones, sec_tens, sec_ones}
//   blank     per-digit blank mask, same order as digits
//   mode      00 RUN, 01 SET_MIN, 10 SET_SEC
//   tick_1hz  one-cycle pulse on each seconds advance
module time_set_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int BLINK_DIV    = 12500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [1:0]  mode,
    output logic        tick_1hz
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10
    } state_t;

    // bit 0 = mode button, bit 1 = inc button
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         acc;
    logic [1:0]         acc_d;
    logic [1:0][DW-1:0] db_cnt;

    logic mode_p;
    logic inc_p;

    state_t        state;
    logic [TW-1:0] pre;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [7:0]    min_r;
    logic [7:0]    sec_r;
    logic [7:0]    min_nx;
    logic [7:0]    sec_nx;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Accepted level flips only after DEBOUNCE_CYC straight cycles
    // of disagreement; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            acc    <= '0;
            acc_d  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= {btn_inc, btn_mode};
            sync2 <= sync1;
            acc_d <= acc;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db_cnt[i] <= '0;
                    acc[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Mode wins a same-cycle collision; inc is dropped.
    assign mode_p = acc[0] & ~acc_d[0];
    assign inc_p  = acc[1] & ~acc_d[1] & ~mode_p;

    assign tick_1hz = (state == RUN) && (pre == TICK_MAX);

    always_comb begin
        sec_nx = bcd_inc(sec_r);
        min_nx = bcd_inc(min_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pre       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            min_r     <= 8'h00;
            sec_r     <= 8'h00;
        end else begin
            // Restart blink on mode change so the new field shows first.
            if (mode_p) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // Held at 0 while editing and on leaving RUN or re-entering it.
            if (state != RUN || mode_p) begin
                pre <= '0;
            end else if (pre == TICK_MAX) begin
                pre <= '0;
            end else begin
                pre <= pre + 1'b1;
            end

            if (mode_p) begin
                unique case (state)
                    RUN:     state <= SET_MIN;
                    SET_MIN: state <= SET_SEC;
                    default: state <= RUN;
                endcase
            end

            if (tick_1hz) begin
                sec_r <= sec_nx;
                if (sec_r == 8'h59) begin
                    min_r <= min_nx;
                end
            end else if (inc_p && state == SET_MIN) begin
                min_r <= min_nx;
            end else if (inc_p && state == SET_SEC) begin
                sec_r <= sec_nx;
            end
        end
    end

    always_comb begin
        blank = 4'b0000;
        unique case (1'b1)
            state == SET_MIN: blank = {phase, phase, 2'b00};
            state == SET_SEC: blank = {2'b00, phase, phase};
            default:          blank = 4'b0000;
        endcase
    end

    assign digits = {min_r, sec_r};
    assign mode   = state;

endmodule
